regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
//
// PURPOSE
//  Shares the single register-file write port between NUM_REQ write-back producers (e.g. ALU, load
//  unit, DMA) using fair round-robin arbitration with a valid/ready handshake, and drives the
//  registered write port (We/Index_Dst/Data) of the lane register file. Also keeps a per-entry
//  pending-write scoreboard so the index stage can stall source reads on RAW hazards.
//
// PARAMETERS
//  NUM_REQ    3    number of write-back requesters (>=2)
//  NUM_ENTRY  64   register-file entries tracked by the scoreboard
//  IDX_W      6    index width, = clog2(NUM_ENTRY)
//  DATA_W     32   write-back data width
//
// PORTS
//  clock         in   1                single clock
//  reset         in   1                asynchronous, active-low reset
//  I_WB_Valid    in   NUM_REQ          requester r has a write-back pending
//  I_WB_Index    in   NUM_REQ*IDX_W    destination index, requester r at [r*IDX_W +: IDX_W]
//  I_WB_Data     in   NUM_REQ*DATA_W   write-back data, requester r at [r*DATA_W +: DATA_W]
//  O_WB_Ready    out  NUM_REQ          one-hot grant; transfer when Valid[r] & Ready[r]
//  O_We          out  1                register-file write enable
//  O_Index_Dst   out  IDX_W            register-file write index
//  O_Data        out  DATA_W           register-file write data
//  I_Issue       in   1                index stage issues an instr. that will write I_Issue_Dst
//  I_Issue_Dst   in   IDX_W            destination index being allocated
//  I_Chk_V1      in   1                source-1 read valid (register-file source)
//  I_Chk_Idx1    in   IDX_W            source-1 index
//  I_Chk_V2      in   1                source-2 read valid
//  I_Chk_Idx2    in   IDX_W            source-2 index
//  O_Stall       out  1                RAW hazard on a checked source; hold issue
//  O_Err         out  1                sticky protocol error (see below)
//
// BEHAVIOUR
//  - Reset (reset==0, async): O_We=0, O_Index_Dst=0, O_Data=0, O_Err=0, RR pointer=0, all busy
//    bits=0. O_WB_Ready/O_Stall are combinational and evaluate to 0 with no valid inputs.
//    Reset mid-operation drops any transfer in flight; no write is performed.
//  - Arbitration: grant = first r with I_WB_Valid[r]=1 scanning ptr, ptr+1, ... mod NUM_REQ.
//    O_WB_Ready is one-hot to that r (all 0 when no valid). Ready never asserted to idle requester.
//    After a transfer, ptr <= (granted r + 1) mod NUM_REQ; unchanged on idle cycles.
//  - Write port: registered, latency 1. Transfer in cycle t -> O_We=1, O_Index_Dst, O_Data
//    valid in cycle t+1 for exactly one cycle. Back-to-back transfers give O_We=1 every cycle.
//    Requesters hold Index/Data stable while Valid & !Ready.
//  - Scoreboard: busy[i] set at clock edge when I_Issue & I_Issue_Dst==i; cleared when
//    O_We & O_Index_Dst==i (commit cycle). Same-cycle set and clear of same i: set wins.
//  - O_Stall = (I_Chk_V1 & busy[I_Chk_Idx1]) | (I_Chk_V2 & busy[I_Chk_Idx2]); combinational
//    from registered busy, no bypass (value visible to reads the cycle after O_We).
//  - O_Err set (sticky until reset) when: I_Issue to an already-busy index (WAW), or O_We commits
//    to an index whose busy bit is 0 and is not set the same cycle (orphan write-back).
//  - Index arithmetic: indices compared as unsigned IDX_W bits; no wrap/aliasing beyond NUM_ENTRY.
//
// TESTING
//  - Reset: assert reset=0 mid-stream -> O_We=0, O_Err=0, busy all 0, O_WB_Ready=0 immediately.
//  - Single req: r1 Valid, Index=5, Data=32'hDEAD_BEEF -> Ready[1]=1 in t, O_We=1/5/DEADBEEF in t+1.
//  - Fairness: all 3 Valid held 6 cycles, ptr=0 -> grants 0,1,2,0,1,2; O_We high 6 consecutive cycles.
//  - Skip idle: Valid=3'b101, ptr=1 -> grant r2, then r0; r1 never Ready.
//  - Hazard: Issue dst=7; Chk_Idx1=7 -> O_Stall=1 until cycle after O_We on 7, then 0.
//  - Errors: Issue dst=9 twice -> O_Err=1; fresh reset, write-back to idx 3 never issued -> O_Err=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter that shares the lane register-file write port among
//   NUM_REQ write-back producers. It also keeps a pending-write scoreboard
//   that the index stage uses to stall RAW hazards.
//
//   clock, reset       : clock and asynchronous active-low reset
//   I_WB_Valid/Index/Data : per-requester write-back request (packed per r)
//   O_WB_Ready         : one-hot grant; a transfer happens on Valid & Ready
//   O_We/Index_Dst/Data : registered register-file write port (latency 1)
//   I_Issue/I_Issue_Dst : destination allocation from the index stage
//   I_Chk_V*/I_Chk_Idx* : source reads to check against the scoreboard
//   O_Stall            : RAW hazard on a checked source
//   O_Err              : sticky WAW-issue / orphan write-back error
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned NUM_ENTRY = 64,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          I_WB_Valid,
  input  logic [NUM_REQ*IDX_W-1:0]    I_WB_Index,
  input  logic [NUM_REQ*DATA_W-1:0]   I_WB_Data,
  output logic [NUM_REQ-1:0]          O_WB_Ready,
  output logic                        O_We,
  output logic [IDX_W-1:0]            O_Index_Dst,
  output logic [DATA_W-1:0]           O_Data,
  input  logic                        I_Issue,
  input  logic [IDX_W-1:0]            I_Issue_Dst,
  input  logic                        I_Chk_V1,
  input  logic [IDX_W-1:0]            I_Chk_Idx1,
  input  logic                        I_Chk_V2,
  input  logic [IDX_W-1:0]            I_Chk_Idx2,
  output logic                        O_Stall,
  output logic                        O_Err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     ptr;
  logic [NUM_ENTRY-1:0] busy;

  logic                 gnt_v;
  logic [PTR_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  int unsigned          cand;
  logic [PTR_W-1:0]     cand_idx;
  int unsigned          nxt;
  logic [PTR_W-1:0]     nxt_ptr;

  logic [IDX_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    sel_data;

  logic [NUM_ENTRY-1:0] set_vec;
  logic [NUM_ENTRY-1:0] clr_vec;
  logic                 err_set;

  // Scan requesters starting at ptr, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    gnt_v    = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!gnt_v && I_WB_Valid[cand_idx]) begin
        gnt_v            = 1'b1;
        gnt_idx          = cand_idx;
        gnt_oh[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    nxt = 32'(gnt_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    nxt_ptr = PTR_W'(nxt);
  end

  assign sel_idx  = I_WB_Index[gnt_idx*IDX_W +: IDX_W];
  assign sel_data = I_WB_Data[gnt_idx*DATA_W +: DATA_W];

  // Grant is suppressed while reset is held so no requester sees a handshake
  // that the write port will never perform.
  assign O_WB_Ready = reset ? gnt_oh : '0;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (I_Issue) set_vec[I_Issue_Dst] = 1'b1;
    if (O_We)    clr_vec[O_Index_Dst] = 1'b1;
  end

  // WAW issue, or a commit to an index that is neither busy nor being
  // allocated in the same cycle.
  assign err_set = (I_Issue & busy[I_Issue_Dst]) |
                   (O_We & ~busy[O_Index_Dst] & ~set_vec[O_Index_Dst]);

  assign O_Stall = (I_Chk_V1 & busy[I_Chk_Idx1]) | (I_Chk_V2 & busy[I_Chk_Idx2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      busy        <= '0;
      O_We        <= 1'b0;
      O_Index_Dst <= '0;
      O_Data      <= '0;
      O_Err       <= 1'b0;
    end else begin
      O_We <= gnt_v;
      if (gnt_v) begin
        O_Index_Dst <= sel_idx;
        O_Data      <= sel_data;
        ptr         <= nxt_ptr;
      end
      // Set applied after clear so a same-cycle allocation wins.
      busy <= (busy & ~clr_vec) | set_vec;
      if (err_set) O_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int NE = 64;
  localparam int IW = 6;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     wb_valid;
  logic [NR*IW-1:0]  wb_index;
  logic [NR*DW-1:0]  wb_data;
  logic [NR-1:0]     wb_ready;
  logic              we;
  logic [IW-1:0]     idx_dst;
  logic [DW-1:0]     data;
  logic              issue;
  logic [IW-1:0]     issue_dst;
  logic              chk_v1, chk_v2;
  logic [IW-1:0]     chk_idx1, chk_idx2;
  logic              stall;
  logic              err;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .NUM_REQ  (NR),
    .NUM_ENTRY(NE),
    .IDX_W    (IW),
    .DATA_W   (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_WB_Valid (wb_valid),
    .I_WB_Index (wb_index),
    .I_WB_Data  (wb_data),
    .O_WB_Ready (wb_ready),
    .O_We       (we),
    .O_Index_Dst(idx_dst),
    .O_Data     (data),
    .I_Issue    (issue),
    .I_Issue_Dst(issue_dst),
    .I_Chk_V1   (chk_v1),
    .I_Chk_Idx1 (chk_idx1),
    .I_Chk_V2   (chk_v2),
    .I_Chk_Idx2 (chk_idx2),
    .O_Stall    (stall),
    .O_Err      (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr;
  bit            m_busy[NE];
  bit            m_err;
  bit            p_v;
  logic [IW-1:0] p_idx;
  logic [DW-1:0] p_data;
  int            m_g;
  logic [NR-1:0] m_rdy;
  bit            m_stall;

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_we", we, 0);
      check("rst_err", err, 0);
      check("rst_ready", wb_ready, 0);
      check("rst_stall", stall, 0);
      check("rst_idx", idx_dst, 0);
      check("rst_data", data, 0);
      m_ptr = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_err = 1'b0;
      p_v   = 1'b0;
    end else begin
      m_g   = pick(wb_valid, m_ptr);
      m_rdy = '0;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      check("ready", wb_ready, m_rdy);
      check("we", we, p_v);
      if (p_v) begin
        check("index_dst", idx_dst, p_idx);
        check("data", data, p_data);
      end
      m_stall = (chk_v1 && m_busy[chk_idx1]) || (chk_v2 && m_busy[chk_idx2]);
      check("stall", stall, m_stall);
      check("err", err, m_err);
      // advance model across the coming clock edge
      if (issue && m_busy[issue_dst]) m_err = 1'b1;
      if (p_v && !m_busy[p_idx] && !(issue && issue_dst == p_idx)) m_err = 1'b1;
      if (p_v) m_busy[p_idx] = 1'b0;
      if (issue) m_busy[issue_dst] = 1'b1;
      if (m_g >= 0) begin
        m_ptr  = (m_g + 1) % NR;
        p_v    = 1'b1;
        p_idx  = wb_index[m_g*IW +: IW];
        p_data = wb_data[m_g*DW +: DW];
      end else begin
        p_v = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  logic [NR-1:0] fair_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wb_valid = '0; wb_index = '0; wb_data = '0;
    issue = 1'b0; issue_dst = '0;
    chk_v1 = 1'b0; chk_v2 = 1'b0; chk_idx1 = '0; chk_idx2 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // single requester
    wb_valid = 3'b010;
    wb_index[1*IW +: IW] = 6'd5;
    wb_data[1*DW +: DW]  = 32'hDEAD_BEEF;
    issue = 1'b1; issue_dst = 6'd5;
    mid(); check("single_ready", wb_ready, 3'b010);
    cyc(); wb_valid = '0; issue = 1'b0;
    mid();
    check("single_we", we, 1);
    check("single_idx", idx_dst, 5);
    check("single_data", data, 32'hDEAD_BEEF);
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;

    // fairness from ptr=0
    for (int c = 0; c < 6; c++) begin
      wb_valid = '1;
      for (int r = 0; r < NR; r++) begin
        wb_index[r*IW +: IW] = IW'(10 + c);
        wb_data[r*DW +: DW]  = 32'hA000_0000 | (r << 8) | c;
      end
      issue = 1'b1; issue_dst = IW'(10 + c);
      mid();
      check("fair_grant", wb_ready, fair_exp[c]);
      if (c > 0) check("fair_we", we, 1);
      cyc();
    end
    wb_valid = '0; issue = 1'b0;
    mid(); check("fair_we_last", we, 1);
    cyc();

    // skip idle requester
    wb_valid = 3'b001; wb_index[0 +: IW] = 6'd20; issue = 1'b1; issue_dst = 6'd20;
    mid(); check("pre_skip", wb_ready, 3'b001);
    cyc();
    wb_valid = 3'b101;
    wb_index[0 +: IW] = 6'd21; wb_index[2*IW +: IW] = 6'd22;
    wb_data[0 +: DW] = 32'h21; wb_data[2*DW +: DW] = 32'h22;
    issue_dst = 6'd22;
    mid(); check("skip_r2", wb_ready, 3'b100);
    cyc();
    wb_valid = 3'b001; issue_dst = 6'd21;
    mid(); check("skip_r0", wb_ready, 3'b001);
    cyc();
    wb_valid = '0; issue = 1'b0;
    mid(); check("skip_we_idx", idx_dst, 21);
    cyc();

    // RAW hazard
    issue = 1'b1; issue_dst = 6'd7; chk_v1 = 1'b1; chk_idx1 = 6'd7;
    mid(); check("haz_pre", stall, 0);
    cyc(); issue = 1'b0;
    mid(); check("haz_busy", stall, 1);
    cyc(); chk_v1 = 1'b0; chk_v2 = 1'b1; chk_idx2 = 6'd7;
    mid(); check("haz_src2", stall, 1);
    cyc(); chk_v2 = 1'b0; chk_v1 = 1'b1;
    wb_valid = 3'b010; wb_index[1*IW +: IW] = 6'd7; wb_data[1*DW +: DW] = 32'h77;
    mid(); check("haz_xfer", stall, 1);
    cyc(); wb_valid = '0;
    mid(); check("haz_commit_we", we, 1); check("haz_commit_stall", stall, 1);
    cyc();
    mid(); check("haz_clear", stall, 0);
    cyc(); chk_v1 = 1'b0;

    // WAW error
    issue = 1'b1; issue_dst = 6'd9;
    mid(); check("err_pre", err, 0);
    cyc();
    mid(); check("err_waw_cycle", err, 0);
    cyc(); issue = 1'b0;
    mid(); check("err_waw", err, 1);

    // reset mid-stream
    cyc(); wb_valid = '1; chk_v1 = 1'b1; chk_idx1 = 6'd9;
    mid(); check("pre_rst_stall", stall, 1);
    cyc();
    check("pre_rst_we", we, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_we", we, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_ready", wb_ready, 0);
    check("rst_mid_stall", stall, 0);
    cyc(); reset = 1'b1; wb_valid = '0; chk_v1 = 1'b0;

    // orphan write-back
    wb_valid = 3'b001; wb_index[0 +: IW] = 6'd3; wb_data[0 +: DW] = 32'h33;
    mid();
    cyc(); wb_valid = '0;
    mid();
    check("orphan_we", we, 1);
    check("orphan_idx", idx_dst, 3);
    check("orphan_err_pre", err, 0);
    cyc();
    mid(); check("orphan_err", err, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
